cms_axis_width_downsizer: RTL



---
 rtl/cms_axis_width_downsizer.sv | 119 +++++++++++
 1 files changed

// File: rtl/cms_axis_width_downsizer.sv
// rtl/cms_axis_width_downsizer.sv - AXI-Stream width downsizer for trace items
//
// Purpose: holds one IN_WIDTH trace item and replays it as NBEATS narrower
// OUT_WIDTH beats, low bits first. tlast of the item lands on its final beat,
// and tkeep trims the partial final beat. A new item may be loaded in the
// same cycle the final beat is accepted, so back-to-back items have no bubble.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   S_AXIS_tvalid/tready/tdata/tlast   wide item input
//   M_AXIS_tvalid/tready/tdata/tkeep/tlast   narrow beat output
//   item_count                    items accepted since reset (wrapping)
module cms_axis_width_downsizer #(
  parameter int IN_WIDTH    = 160,
  parameter int OUT_WIDTH   = 64,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     S_AXIS_tvalid,
  output logic                     S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]      S_AXIS_tdata,
  input  logic                     S_AXIS_tlast,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [OUT_WIDTH-1:0]     M_AXIS_tdata,
  output logic [OUT_WIDTH/8-1:0]   M_AXIS_tkeep,
  output logic                     M_AXIS_tlast,
  output logic [COUNT_WIDTH-1:0]   item_count
);

  localparam int NBEATS     = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int PAD_W      = NBEATS * OUT_WIDTH;
  localparam int KEEP_W     = OUT_WIDTH / 8;
  localparam int LAST_BYTES = (IN_WIDTH - (NBEATS - 1) * OUT_WIDTH) / 8;
  localparam logic [KEEP_W-1:0] FULL_KEEP = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);

  logic [IN_WIDTH-1:0]    data_q, data_d;
  logic                   last_q, last_d;
  logic                   full_q, full_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [COUNT_WIDTH-1:0] item_count_q, item_count_d;

  logic             last_beat;
  logic             s_hs;
  logic             m_hs;
  logic [PAD_W-1:0] padded;

  assign last_beat     = (beat_q == BEAT_W'(NBEATS - 1));
  // Ready looks through to the downstream ready on the final beat so the
  // next item can replace the current one without an idle cycle.
  assign S_AXIS_tready = ~full_q | (M_AXIS_tready & last_beat);
  assign s_hs          = S_AXIS_tvalid & S_AXIS_tready;
  assign m_hs          = full_q & M_AXIS_tready;

  assign M_AXIS_tvalid = full_q;
  assign M_AXIS_tlast  = full_q & last_q & last_beat;
  assign M_AXIS_tkeep  = full_q ? (last_beat ? LAST_KEEP : FULL_KEEP) : '0;
  assign item_count    = item_count_q;

  // Zero-extend the item to a whole number of beats so the tail reads as 0.
  always_comb begin
    padded                 = '0;
    padded[IN_WIDTH-1:0]   = data_q;
  end

  always_comb begin
    M_AXIS_tdata = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat_q == BEAT_W'(i)) begin
        M_AXIS_tdata = padded[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_comb begin
    data_d       = data_q;
    last_d       = last_q;
    full_d       = full_q;
    beat_d       = beat_q;
    item_count_d = item_count_q;
    if (m_hs) begin
      if (last_beat) begin
        beat_d = '0;
        full_d = 1'b0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
    // An accept either starts from idle or coincides with the final beat
    // leaving, so the beat index is already heading back to 0.
    if (s_hs) begin
      data_d       = S_AXIS_tdata;
      last_d       = S_AXIS_tlast;
      full_d       = 1'b1;
      beat_d       = '0;
      item_count_d = item_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      last_q       <= 1'b0;
      full_q       <= 1'b0;
      beat_q       <= '0;
      item_count_q <= '0;
    end else begin
      data_q       <= data_d;
      last_q       <= last_d;
      full_q       <= full_d;
      beat_q       <= beat_d;
      item_count_q <= item_count_d;
    end
  end

endmodule
